// File: rtl/seq_tx_pkg.sv
// ----------------------------------------------------------------------------
// seq_tx_pkg
// Shared definitions for the "101"-framed serial link. The transmitter
// (seq_101_frame_tx) and any receiving sync detector import this package so
// both sides agree on the frame state names and the sync preamble.
//   tx_state_t   : transmitter FSM states (idle, sync, data, parity, gap)
//   SYNC_PATTERN : preamble bits, sent MSB first
//   SYNC_LEN     : number of preamble bits
//   sync_bit()   : preamble bit for a given position (0 = first sent)
// ----------------------------------------------------------------------------
package seq_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_DATA = 3'd2,
    ST_PAR  = 3'd3,
    ST_GAP  = 3'd4
  } tx_state_t;

  localparam logic [2:0] SYNC_PATTERN = 3'b101;
  localparam int         SYNC_LEN     = 3;

  // Position 0 is the first preamble bit on the wire (pattern MSB).
  function automatic logic sync_bit(input logic [1:0] idx);
    logic [2:0] pat;
    pat = SYNC_PATTERN;
    return pat[2'(SYNC_LEN - 1) - idx];
  endfunction

endpackage

// File: rtl/seq_101_frame_tx.sv
// ----------------------------------------------------------------------------
// seq_101_frame_tx
// Serialises one payload per handshake into a frame:
//   sync preamble 1,0,1 | payload MSB first | optional even-parity bit
// followed by GAP forced-zero cycles before the next payload is accepted.
//
// Parameters
//   DATA_W    : payload bits per frame (>= 1)
//   PARITY_EN : 1 appends the XOR of all payload bits after the payload
//   GAP       : forced-0 cycles after each frame (>= 0)
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset (aborts any frame at once)
//   tx_data    : payload, sampled only on the accepting edge
//   tx_valid   : payload offered
//   tx_ready   : high exactly while idle (acceptance = tx_valid && tx_ready)
//   dout       : registered serial bitstream, 0 when idle or in the gap
//   busy       : frame or gap in progress
//   frame_done : one-cycle pulse while dout carries the last frame bit
//
// The state register names the bit dout is carrying in the current cycle, so
// every transition loads dout with the first bit of the state being entered.
// ----------------------------------------------------------------------------
module seq_101_frame_tx
  import seq_tx_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int PARITY_EN = 1,
  parameter int GAP       = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              dout,
  output logic              busy,
  output logic              frame_done
);

  // One counter serves the sync, data and gap phases, so it must reach the
  // largest of the three lengths; it is cleared on every phase change and
  // therefore never wraps inside a frame.
  localparam int CNT_MAX_A = (DATA_W > SYNC_LEN) ? DATA_W : SYNC_LEN;
  localparam int CNT_MAX   = (CNT_MAX_A > GAP) ? CNT_MAX_A : GAP;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SYNC_LAST   = CNT_W'(SYNC_LEN - 1);
  localparam logic [CNT_W-1:0] DATA_LAST   = CNT_W'(DATA_W - 1);
  // Index of the payload bit just before the last one; only used without
  // parity, where frame_done must rise together with the final payload bit.
  localparam logic [CNT_W-1:0] DATA_PENULT = CNT_W'(DATA_W - 2);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP - 1);

  localparam logic HAS_PAR     = (PARITY_EN != 0);
  localparam logic HAS_GAP     = (GAP > 0);
  // Single-bit payload without parity: the first data bit is also the last.
  localparam logic DONE_ON_MSB = !HAS_PAR && (DATA_W == 1);

  tx_state_t         state_reg;
  logic [DATA_W-1:0] shift_reg;
  logic              parity_reg;
  logic [CNT_W-1:0]  bit_cnt_reg;

  assign tx_ready = (state_reg == ST_IDLE);
  assign busy     = !tx_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      shift_reg   <= '0;
      parity_reg  <= 1'b0;
      bit_cnt_reg <= '0;
      dout        <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      // Default: line low, no pulse. Branches override for the bit they emit.
      dout       <= 1'b0;
      frame_done <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (tx_valid) begin
            shift_reg   <= tx_data;
            parity_reg  <= ^tx_data;
            bit_cnt_reg <= '0;
            dout        <= sync_bit(2'd0);
            state_reg   <= ST_SYNC;
          end
        end

        ST_SYNC: begin
          if (bit_cnt_reg == SYNC_LAST) begin
            bit_cnt_reg <= '0;
            dout        <= shift_reg[DATA_W-1];
            shift_reg   <= shift_reg << 1;
            frame_done  <= DONE_ON_MSB;
            state_reg   <= ST_DATA;
          end else begin
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
            dout        <= sync_bit(bit_cnt_reg[1:0] + 2'd1);
          end
        end

        ST_DATA: begin
          if (bit_cnt_reg == DATA_LAST) begin
            bit_cnt_reg <= '0;
            if (HAS_PAR) begin
              dout       <= parity_reg;
              frame_done <= 1'b1;
              state_reg  <= ST_PAR;
            end else if (HAS_GAP) begin
              state_reg <= ST_GAP;
            end else begin
              state_reg <= ST_IDLE;
            end
          end else begin
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
            dout        <= shift_reg[DATA_W-1];
            shift_reg   <= shift_reg << 1;
            frame_done  <= !HAS_PAR && (bit_cnt_reg == DATA_PENULT);
          end
        end

        ST_PAR: begin
          bit_cnt_reg <= '0;
          state_reg   <= HAS_GAP ? ST_GAP : ST_IDLE;
        end

        ST_GAP: begin
          if (bit_cnt_reg == GAP_LAST) begin
            bit_cnt_reg <= '0;
            state_reg   <= ST_IDLE;
          end else begin
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
          end
        end

        // Unused encodings recover to idle with the line held low.
        default: begin
          bit_cnt_reg <= '0;
          state_reg   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
